// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, writeback bypass
// into the operand latches, and a saturating stall counter.
module id_ex_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [31:0] id_pc,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic [31:0] id_imm,
    input  logic [3:0]  id_aluop,
    input  logic        id_regwrite,
    input  logic        id_memread,
    input  logic        id_memwrite,
    input  logic        id_memtoreg,
    input  logic        id_alusrc,
    input  logic        id_regdst,
    input  logic [31:0] rf_outa,
    input  logic [31:0] rf_outb,
    input  logic        flush,
    input  logic        wb_we,
    input  logic [4:0]  wb_wrreg,
    input  logic [31:0] wb_data,
    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_a,
    output logic [31:0] ex_b,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rs,
    output logic [4:0]  ex_rt,
    output logic [4:0]  ex_dest,
    output logic [3:0]  ex_aluop,
    output logic        ex_regwrite,
    output logic        ex_memread,
    output logic        ex_memwrite,
    output logic        ex_memtoreg,
    output logic        ex_alusrc,
    output logic        stall,
    output logic [15:0] stall_count
);

    logic        w_stall;
    logic        w_bubble;
    logic [4:0]  w_dest;
    logic        w_byp_a;
    logic        w_byp_b;

    // A load in EX whose result the ID instruction needs cannot be forwarded in time.
    assign w_stall  = id_valid & ex_valid & ex_memread & (ex_dest != 5'd0) &
                      ((ex_dest == id_rs) | (ex_dest == id_rt));
    assign stall    = w_stall;
    assign w_bubble = flush | w_stall | ~id_valid;
    assign w_dest   = id_regdst ? id_rd : id_rt;
    assign w_byp_a  = wb_we & (wb_wrreg != 5'd0) & (wb_wrreg == id_rs);
    assign w_byp_b  = wb_we & (wb_wrreg != 5'd0) & (wb_wrreg == id_rt);

    always_ff @(posedge clock) begin
        if (reset) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_a        <= '0;
            ex_b        <= '0;
            ex_imm      <= '0;
            ex_rs       <= '0;
            ex_rt       <= '0;
            ex_dest     <= '0;
            ex_aluop    <= '0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_memtoreg <= 1'b0;
            ex_alusrc   <= 1'b0;
            stall_count <= '0;
        end else begin
            if (w_stall && stall_count != 16'hFFFF)
                stall_count <= stall_count + 16'd1;
            if (w_bubble) begin
                // Clearing memread here is what limits a load-use stall to one cycle.
                ex_valid    <= 1'b0;
                ex_pc       <= '0;
                ex_a        <= '0;
                ex_b        <= '0;
                ex_imm      <= '0;
                ex_rs       <= '0;
                ex_rt       <= '0;
                ex_dest     <= '0;
                ex_aluop    <= '0;
                ex_regwrite <= 1'b0;
                ex_memread  <= 1'b0;
                ex_memwrite <= 1'b0;
                ex_memtoreg <= 1'b0;
                ex_alusrc   <= 1'b0;
            end else begin
                ex_valid    <= 1'b1;
                ex_pc       <= id_pc;
                ex_a        <= w_byp_a ? wb_data : rf_outa;
                ex_b        <= w_byp_b ? wb_data : rf_outb;
                ex_imm      <= id_imm;
                ex_rs       <= id_rs;
                ex_rt       <= id_rt;
                ex_dest     <= w_dest;
                ex_aluop    <= id_aluop;
                ex_regwrite <= id_regwrite & (w_dest != 5'd0);
                ex_memread  <= id_memread;
                ex_memwrite <= id_memwrite;
                ex_memtoreg <= id_memtoreg;
                ex_alusrc   <= id_alusrc;
            end
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Random + directed bench for id_ex_stage against a behavioural model of the
// pipeline register contents.
module tb_id_ex_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_imm;
    logic [3:0]  id_aluop;
    logic        id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc, id_regdst;
    logic [31:0] rf_outa, rf_outb;
    logic        flush;
    logic        wb_we;
    logic [4:0]  wb_wrreg;
    logic [31:0] wb_data;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_a, ex_b, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_dest;
    logic [3:0]  ex_aluop;
    logic        ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc;
    logic        stall;
    logic [15:0] stall_count;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;
    bit m_en = 1'b1;

    typedef struct {
        bit          valid;
        logic [31:0] pc, a, b, imm;
        logic [4:0]  rs, rt, dest;
        logic [3:0]  aluop;
        bit          regwrite, memread, memwrite, memtoreg, alusrc;
    } ex_t;

    ex_t m;
    int  m_cnt = 0;

    id_ex_stage dut (
        .clock(clock), .reset(reset),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_imm(id_imm), .id_aluop(id_aluop),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
        .id_memtoreg(id_memtoreg), .id_alusrc(id_alusrc), .id_regdst(id_regdst),
        .rf_outa(rf_outa), .rf_outb(rf_outb), .flush(flush),
        .wb_we(wb_we), .wb_wrreg(wb_wrreg), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest), .ex_aluop(ex_aluop),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_memtoreg(ex_memtoreg), .ex_alusrc(ex_alusrc),
        .stall(stall), .stall_count(stall_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // A hazard exists when the instruction sitting in EX is a valid load to a
    // non-zero register that the decoding instruction reads.
    function automatic bit model_stall();
        bit reads_it;
        reads_it = (m.dest == id_rs) || (m.dest == id_rt);
        return id_valid && m.valid && m.memread && m.dest != 0 && reads_it;
    endfunction

    function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] rf);
        if (wb_we && wb_wrreg != 0 && wb_wrreg == r) return wb_data;
        return rf;
    endfunction

    always @(posedge clock) begin
        if (m_en) begin
            bit s;
            ex_t n;
            s = model_stall();
            n = '{default: '0};
            if (reset) begin
                m = n;
                m_cnt = 0;
            end else begin
                if (s) m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
                if (!(flush || s || !id_valid)) begin
                    n.valid    = 1;
                    n.pc       = id_pc;
                    n.imm      = id_imm;
                    n.rs       = id_rs;
                    n.rt       = id_rt;
                    n.aluop    = id_aluop;
                    n.dest     = id_regdst ? id_rd : id_rt;
                    n.a        = operand(id_rs, rf_outa);
                    n.b        = operand(id_rt, rf_outb);
                    n.regwrite = id_regwrite && n.dest != 0;
                    n.memread  = id_memread;
                    n.memwrite = id_memwrite;
                    n.memtoreg = id_memtoreg;
                    n.alusrc   = id_alusrc;
                end
                m = n;
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("stall", {31'd0, stall}, {31'd0, model_stall()});
            chk("ex_valid", {31'd0, ex_valid}, {31'd0, m.valid});
            chk("ex_pc", ex_pc, m.pc);
            chk("ex_a", ex_a, m.a);
            chk("ex_b", ex_b, m.b);
            chk("ex_imm", ex_imm, m.imm);
            chk("ex_rs", {27'd0, ex_rs}, {27'd0, m.rs});
            chk("ex_rt", {27'd0, ex_rt}, {27'd0, m.rt});
            chk("ex_dest", {27'd0, ex_dest}, {27'd0, m.dest});
            chk("ex_aluop", {28'd0, ex_aluop}, {28'd0, m.aluop});
            chk("ex_ctl", {27'd0, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc},
                {27'd0, m.regwrite, m.memread, m.memwrite, m.memtoreg, m.alusrc});
            chk("stall_count", {16'd0, stall_count}, m_cnt);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clr_in();
        reset = 0; flush = 0; id_valid = 0; id_pc = 0; id_rs = 0; id_rt = 0; id_rd = 0;
        id_imm = 0; id_aluop = 0; id_regwrite = 0; id_memread = 0; id_memwrite = 0;
        id_memtoreg = 0; id_alusrc = 0; id_regdst = 0; rf_outa = 0; rf_outb = 0;
        wb_we = 0; wb_wrreg = 0; wb_data = 0;
    endtask

    task automatic rand_in();
        reset       = ($urandom_range(0, 63) == 0);
        flush       = ($urandom_range(0, 7) == 0);
        id_valid    = ($urandom_range(0, 3) != 0);
        id_pc       = $urandom;
        id_rs       = 5'($urandom_range(0, 3));
        id_rt       = 5'($urandom_range(0, 3));
        id_rd       = 5'($urandom_range(0, 3));
        id_imm      = $urandom;
        id_aluop    = 4'($urandom_range(0, 15));
        id_regwrite = 1'($urandom_range(0, 1));
        id_memread  = 1'($urandom_range(0, 1));
        id_memwrite = 1'($urandom_range(0, 1));
        id_memtoreg = 1'($urandom_range(0, 1));
        id_alusrc   = 1'($urandom_range(0, 1));
        id_regdst   = 1'($urandom_range(0, 1));
        rf_outa     = $urandom;
        rf_outb     = $urandom;
        wb_we       = 1'($urandom_range(0, 1));
        wb_wrreg    = 5'($urandom_range(0, 3));
        wb_data     = $urandom;
    endtask

    initial begin
        clr_in();
        reset = 1;
        tick();
        tick();
        chk("rst ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst stall_count", {16'd0, stall_count}, 32'd0);
        chk("rst stall", {31'd0, stall}, 32'd0);
        chk_en = 1;

        // plain capture with rd destination
        clr_in();
        id_valid = 1; id_rs = 3; id_rt = 4; id_rd = 5; id_regdst = 1;
        rf_outa = 10; rf_outb = 20; id_regwrite = 1;
        tick();
        chk("cap ex_valid", {31'd0, ex_valid}, 32'd1);
        chk("cap ex_a", ex_a, 32'd10);
        chk("cap ex_b", ex_b, 32'd20);
        chk("cap ex_dest", {27'd0, ex_dest}, 32'd5);
        chk("cap ex_regwrite", {31'd0, ex_regwrite}, 32'd1);

        // load to r7 followed by a reader of r7
        clr_in();
        id_valid = 1; id_rs = 1; id_rt = 7; id_memread = 1; id_regwrite = 1;
        tick();
        clr_in();
        id_valid = 1; id_rs = 7; id_rt = 2; id_rd = 3; id_regdst = 1;
        #1;
        chk("lu stall", {31'd0, stall}, 32'd1);
        tick();
        chk("lu bubble", {31'd0, ex_valid}, 32'd0);
        chk("lu stall clr", {31'd0, stall}, 32'd0);
        chk("lu count", {16'd0, stall_count}, 32'd1);
        tick();
        chk("lu dep valid", {31'd0, ex_valid}, 32'd1);
        chk("lu dep dest", {27'd0, ex_dest}, 32'd3);

        // writeback bypass on rt, then suppressed for $0
        clr_in();
        id_valid = 1; id_rt = 4; wb_we = 1; wb_wrreg = 4; wb_data = 32'hDEADBEEF;
        tick();
        chk("byp ex_b", ex_b, 32'hDEADBEEF);
        wb_wrreg = 0;
        tick();
        chk("byp0 ex_b", ex_b, 32'd0);

        // writes to $0 never propagate
        clr_in();
        id_valid = 1; id_regwrite = 1; id_regdst = 0; id_rt = 0; id_rd = 9;
        tick();
        chk("r0 regwrite", {31'd0, ex_regwrite}, 32'd0);
        chk("r0 dest", {27'd0, ex_dest}, 32'd0);

        // flush coinciding with a load-use stall, then reset
        clr_in();
        id_valid = 1; id_rt = 7; id_memread = 1;
        tick();
        clr_in();
        id_valid = 1; id_rs = 7; flush = 1;
        #1;
        chk("fs stall", {31'd0, stall}, 32'd1);
        tick();
        chk("fs bubble", {31'd0, ex_valid}, 32'd0);
        chk("fs count", {16'd0, stall_count}, 32'd2);
        clr_in();
        reset = 1;
        tick();
        chk("fs rst count", {16'd0, stall_count}, 32'd0);
        chk("fs rst valid", {31'd0, ex_valid}, 32'd0);

        repeat (3000) begin
            rand_in();
            tick();
        end

        // Hold the EX stage as a load to r7 so every cycle is a stall.
        chk_en = 0;
        m_en = 0;
        clr_in();
        reset = 1;
        tick();
        clr_in();
        id_valid = 1; id_rs = 7;
        force dut.ex_valid = 1'b1;
        force dut.ex_memread = 1'b1;
        force dut.ex_dest = 5'd7;
        #1;
        chk("sat stall", {31'd0, stall}, 32'd1);
        repeat (65534) tick();
        chk("sat pre", {16'd0, stall_count}, 32'h0000FFFE);
        tick();
        chk("sat top", {16'd0, stall_count}, 32'h0000FFFF);
        tick();
        chk("sat hold", {16'd0, stall_count}, 32'h0000FFFF);
        repeat (5) tick();
        chk("sat nowrap", {16'd0, stall_count}, 32'h0000FFFF);
        release dut.ex_valid;
        release dut.ex_memread;
        release dut.ex_dest;
        clr_in();
        reset = 1;
        m_en = 1;
        tick();
        chk_en = 1;
        chk("post rst count", {16'd0, stall_count}, 32'd0);
        repeat (200) begin
            rand_in();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have ports: clock in 1 (rising-edge; sole clock); reset in 1 (synchronous, active-high).
REQ-002 SHALL have inputs id_valid 1, id_pc 32, id_rs 5, id_rt 5, id_rd 5, id_imm 32 (already sign-extended), id_aluop 4.
REQ-003 SHALL have control inputs id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc, id_regdst, each 1 bit.
REQ-004 SHALL have inputs rf_outa 32 and rf_outb 32 (register-file read data for id_rs and id_rt), plus flush in 1.
REQ-005 SHALL have writeback-snoop inputs wb_we 1, wb_wrreg 5, wb_data 32, identical to the register-file write port.
REQ-006 SHALL have outputs ex_valid 1, ex_pc 32, ex_a 32, ex_b 32, ex_imm 32, ex_rs 5, ex_rt 5, ex_dest 5, ex_aluop 4.
REQ-007 SHALL have outputs ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc, each 1 bit, plus stall out 1 and stall_count out 16.

Function
REQ-008 All ex_* outputs and stall_count SHALL be registers updated only on rising clock.
REQ-009 stall SHALL be combinational: 1 iff id_valid & ex_valid & ex_memread & ex_dest!=0 & (ex_dest==id_rs | ex_dest==id_rt).
REQ-010 Normal capture (no reset, no flush, stall=0): ex_valid<=id_valid, all fields <= corresponding id_* values; latency one cycle.
REQ-011 ex_dest SHALL be id_rd when id_regdst=1, else id_rt.
REQ-012 ex_regwrite SHALL be id_regwrite & id_valid & (selected dest!=0); writes to $0 are never propagated.
REQ-013 Bypass: when wb_we=1, wb_wrreg!=0, wb_wrreg==id_rs, ex_a SHALL capture wb_data instead of rf_outa; same rule for id_rt -> ex_b; both may bypass in the same cycle.
REQ-014 Without bypass, ex_a/ex_b SHALL capture rf_outa/rf_outb unchanged (32-bit, no width change).
REQ-015 Bubble (stall=1 or flush=1): ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc SHALL load 0; data fields and ex_dest SHALL load 0.
REQ-016 flush SHALL take priority over stall; flush and stall together produce one bubble, stall_count is still incremented.
REQ-017 Because a bubble clears ex_memread, a load-use stall SHALL last exactly one cycle per dependent instruction.
REQ-018 stall_count SHALL increment by 1 on each rising edge where stall=1, saturating at 16'hFFFF (no wrap).
REQ-019 id_valid=0 with no stall/flush SHALL load a bubble (ex_valid=0, all controls 0).
REQ-020 Block SHALL NOT hold upstream state; upstream (IF/ID) uses stall to freeze itself.

Reset
REQ-021 reset=1 at a rising edge SHALL clear every ex_* output and stall_count to 0, overriding flush, stall and capture.
REQ-022 While reset is held, stall SHALL read 0 from the second cycle onward (ex_valid=0); reset mid-stall abandons the stall.
REQ-023 No initial-block values SHALL be relied upon; state is defined only after the first reset edge.

Verification
REQ-024 Capture: id_valid=1, id_rs=3, id_rt=4, id_rd=5, id_regdst=1, rf_outa=10, rf_outb=20, id_regwrite=1 -> next cycle ex_valid=1, ex_a=10, ex_b=20, ex_dest=5, ex_regwrite=1.
REQ-025 Load-use: ex holds lw with ex_dest=7, ex_memread=1; id_rs=7 -> stall=1 same cycle, next cycle ex_valid=0, stall=0, stall_count=1; following cycle the dependent instruction is captured.
REQ-026 Bypass: wb_we=1, wb_wrreg=4, wb_data=32'hDEADBEEF, id_rt=4, rf_outb=0 -> ex_b=32'hDEADBEEF; with wb_wrreg=0 -> ex_b=0.
REQ-027 $0 dest: id_regwrite=1, id_regdst=0, id_rt=0 -> ex_regwrite=0, ex_dest=0.
REQ-028 Flush+stall: load-use condition and flush=1 same cycle -> bubble, stall_count +1; reset asserted next edge -> all outputs 0, stall_count=0.
REQ-029 Saturation: force 65536 consecutive stalls -> stall_count remains 16'hFFFF.
